// File: rtl/lea_pkg.sv
// ---------------------------------------------------------------------------
// lea_pkg
// Shared definitions for the LEA datapath blocks.
//   LEA_WORD_W : native LEA word width
//   lea_state_e: control FSM states of the bit-serial add/subtract unit
//   OP_ADD/SUB : encoding of the 'sub' operation select input
// ---------------------------------------------------------------------------
package lea_pkg;

    localparam int LEA_WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } lea_state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage : lea_pkg

// File: rtl/lea_serial_adder_ctrl_fa.sv
// ---------------------------------------------------------------------------
// LEA_FullAdder
// One-bit full-adder cell shared by the bit-serial adder.
//   A, B : operand bits
//   Cin  : carry in
//   S    : sum bit
//   Cout : carry out
// ---------------------------------------------------------------------------
module LEA_FullAdder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    logic half_sum;

    assign half_sum = A ^ B;
    assign S        = half_sum ^ Cin;
    assign Cout     = (A & B) | (Cin & half_sum);

endmodule : LEA_FullAdder

// File: rtl/lea_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// lea_serial_adder_ctrl
// Bit-serial modular add/subtract unit. A single full-adder cell is stepped
// over WIDTH cycles, LSB first, producing (a + b) or (a - b) mod 2^WIDTH.
// Ports:
//   clk, rst              : clock (rising edge), async active-high reset
//   in_valid / in_ready   : operand handshake (ready only in IDLE)
//   a, b, sub             : operands and op select (0 = add, 1 = subtract)
//   out_valid / out_ready : result handshake (valid only in DONE)
//   sum, carry_out        : result word and final carry (1 = no borrow on sub)
//   busy                  : high whenever an operation is in RUN or DONE
// ---------------------------------------------------------------------------
module lea_serial_adder_ctrl
    import lea_pkg::*;
#(
    parameter  int WIDTH = LEA_WORD_W,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    lea_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;

    logic             fa_s;
    logic             fa_cout;

    LEA_FullAdder u_fa (
        .A    (a_sh[0]),
        .B    (b_sh[0]),
        .Cin  (carry),
        .S    (fa_s),
        .Cout (fa_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            carry   <= 1'b0;
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        // Subtraction is a + ~b + 1: invert b here and seed
                        // the carry with 1 so the cell only ever adds.
                        a_sh  <= a;
                        b_sh  <= (sub == OP_SUB) ? ~b : b;
                        carry <= sub;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
                    a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
                    carry  <= fa_cout;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        // Capture the finished word into a separate holding
                        // register so sum/carry_out keep the last result
                        // while the next operation shifts through sum_sh.
                        sum_q   <= {fa_s, sum_sh[WIDTH-1:1]};
                        carry_q <= fa_cout;
                        state   <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign sum       = sum_q;
    assign carry_out = carry_q;

endmodule : lea_serial_adder_ctrl
